// File: rtl/isa_pkg.sv
// Shared ISA definitions for the CR16-style sequencer: opcode/opext codes,
// the HALT word and the sequencer state encoding.
package isa_pkg;

  localparam logic [3:0]  OP_RTYPE  = 4'h0;
  localparam logic [3:0]  OP_ADDI   = 4'h1;
  localparam logic [3:0]  OP_ANDI   = 4'h5;
  localparam logic [3:0]  OP_ORI    = 4'h9;
  localparam logic [3:0]  OP_CMPI   = 4'hB;
  localparam logic [3:0]  OP_MOVI   = 4'hD;

  localparam logic [3:0]  EXT_CMP   = 4'hB;

  localparam logic [15:0] HALT_WORD = 16'hFFFF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_WAIT   = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction-memory fetch handshake between the sequencer (master) and memory (slave).
interface instr_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             mem_req;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_ack;
  logic [WIDTH-1:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input  mem_ack, input  mem_rdata);
  modport slave  (input  mem_req, input  mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/instr_sequencer_decode.sv
// Combinational instruction decode: splits an instruction word into datapath
// fields and classifies it as register-writing, immediate-using or HALT.
module instr_decode
  import isa_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
) (
  input  logic [WIDTH-1:0]   ir_i,
  output logic [3:0]         opcode_o,
  output logic [3:0]         opext_o,
  output logic [REGBITS-1:0] ra1_o,
  output logic [REGBITS-1:0] ra2_o,
  output logic signed [WIDTH-1:0] imm_o,
  output logic               use_imm_o,
  output logic               writes_reg_o,
  output logic               is_halt_o
);

  always_comb begin
    opcode_o  = ir_i[15:12];
    opext_o   = ir_i[7:4];
    ra1_o     = ir_i[8 +: REGBITS];
    ra2_o     = ir_i[0 +: REGBITS];
    imm_o     = {{(WIDTH-8){ir_i[7]}}, ir_i[7:0]};
    use_imm_o = (ir_i[15:12] != OP_RTYPE);
    is_halt_o = (ir_i == HALT_WORD);

    // CMP in either form and every undefined opcode retire without a write
    unique case (ir_i[15:12])
      OP_RTYPE:                          writes_reg_o = (ir_i[7:4] != EXT_CMP);
      OP_ADDI, OP_ANDI, OP_ORI, OP_MOVI: writes_reg_o = 1'b1;
      default:                           writes_reg_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multicycle fetch/decode/execute sequencer driving the 16-bit datapath;
// holds PC and IR and issues one regfile write strobe per writing instruction.
module instr_sequencer
  import isa_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  instr_sequencer_if.master  mem,
  output logic [3:0]         opcode,
  output logic [3:0]         opext,
  output logic [REGBITS-1:0] ra1,
  output logic [REGBITS-1:0] ra2,
  output logic [REGBITS-1:0] wa,
  output logic               regwrite,
  output logic               use_imm,
  output logic [WIDTH-1:0]   imm,
  output logic               halted
);

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      pc_q, pc_d;
  logic [WIDTH-1:0]      ir_q, ir_d;
  logic                  mem_req_q;
  logic [WIDTH-1:0]      mem_addr_q;
  logic [3:0]            opcode_q, opext_q;
  logic [REGBITS-1:0]    ra1_q, ra2_q;
  logic signed [WIDTH-1:0] imm_q;
  logic                  use_imm_q, writes_reg_q, is_halt_q;
  logic                  regwrite_q, halted_q;

  logic [3:0]            dec_opcode, dec_opext;
  logic [REGBITS-1:0]    dec_ra1, dec_ra2;
  logic signed [WIDTH-1:0] dec_imm;
  logic                  dec_use_imm, dec_writes_reg, dec_is_halt;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      S_FETCH:  state_d = S_WAIT;
      S_WAIT: begin
        if (mem.mem_ack) begin
          ir_d    = mem.mem_rdata;
          pc_d    = pc_q + WIDTH'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = is_halt_q ? S_HALT : S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Decoding the next IR lets the field registers be valid in the DECODE cycle itself
  instr_decode #(
    .WIDTH   (WIDTH),
    .REGBITS (REGBITS)
  ) u_decode (
    .ir_i         (ir_d),
    .opcode_o     (dec_opcode),
    .opext_o      (dec_opext),
    .ra1_o        (dec_ra1),
    .ra2_o        (dec_ra2),
    .imm_o        (dec_imm),
    .use_imm_o    (dec_use_imm),
    .writes_reg_o (dec_writes_reg),
    .is_halt_o    (dec_is_halt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_FETCH;
      pc_q         <= '0;
      ir_q         <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      opcode_q     <= '0;
      opext_q      <= '0;
      ra1_q        <= '0;
      ra2_q        <= '0;
      imm_q        <= '0;
      use_imm_q    <= 1'b0;
      writes_reg_q <= 1'b0;
      is_halt_q    <= 1'b0;
      regwrite_q   <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      mem_req_q    <= (state_d == S_WAIT);
      mem_addr_q   <= pc_d;
      opcode_q     <= dec_opcode;
      opext_q      <= dec_opext;
      ra1_q        <= dec_ra1;
      ra2_q        <= dec_ra2;
      imm_q        <= dec_imm;
      use_imm_q    <= dec_use_imm;
      writes_reg_q <= dec_writes_reg;
      is_halt_q    <= dec_is_halt;
      regwrite_q   <= (state_d == S_WB) && writes_reg_q;
      halted_q     <= (state_d == S_HALT);
    end
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;
  assign opcode       = opcode_q;
  assign opext        = opext_q;
  assign ra1          = ra1_q;
  assign ra2          = ra2_q;
  assign wa           = ra1_q;
  assign imm          = imm_q;
  assign use_imm      = use_imm_q;
  assign regwrite     = regwrite_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a memory model serves queued words,
// a monitor checks every fetch address, decoded fields and the write strobe.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  opcode, opext, ra1, ra2, wa;
  logic        regwrite, use_imm, halted;
  logic [15:0] imm;

  instr_sequencer_if #(.WIDTH(16)) mif ();

  instr_sequencer #(.WIDTH(16), .REGBITS(4)) dut (
    .clk      (clk),
    .reset    (rst),
    .mem      (mif),
    .opcode   (opcode),
    .opext    (opext),
    .ra1      (ra1),
    .ra2      (ra2),
    .wa       (wa),
    .regwrite (regwrite),
    .use_imm  (use_imm),
    .imm      (imm),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [3:0]  opcode;
    logic [3:0]  opext;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic        use_imm;
    logic [15:0] imm;
    logic        rw;
    logic        halt;
  } exp_t;

  typedef struct packed {
    logic [15:0] word;
    logic [7:0]  dly;
  } mem_t;

  exp_t exp_q[$];
  mem_t mem_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   retired = 0;

  task automatic issue(input logic [15:0] word, input logic [7:0] dly, input logic [15:0] addr,
                       input logic [3:0] op, input logic [3:0] ext, input logic [3:0] r1,
                       input logic [3:0] r2, input logic ui, input logic [15:0] im,
                       input logic rw, input logic hlt);
    mem_t m;
    exp_t e;
    m.word = word; m.dly = dly;
    e.addr = addr; e.opcode = op; e.opext = ext; e.ra1 = r1; e.ra2 = r2;
    e.use_imm = ui; e.imm = im; e.rw = rw; e.halt = hlt;
    mem_q.push_back(m);
    exp_q.push_back(e);
  endtask

  // Memory model: acks the front word after its programmed number of WAIT cycles
  initial begin
    int cnt;
    cnt = 0;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        mif.mem_ack = 1'b0;
        cnt = 0;
      end else if (mif.mem_req && mem_q.size() > 0) begin
        if (cnt == int'(mem_q[0].dly)) begin
          mif.mem_ack   = 1'b1;
          mif.mem_rdata = mem_q[0].word;
          void'(mem_q.pop_front());
          cnt = 0;
        end else begin
          mif.mem_ack = 1'b0;
          cnt++;
        end
      end else begin
        mif.mem_ack = 1'b0;
      end
    end
  end

  // Monitor: samples on the falling edge, compares against the scoreboard
  initial begin
    exp_t cur;
    int   cyc, ack_cyc;
    bit   active;
    cyc = 0; ack_cyc = 0; active = 0; cur = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        active = 0;
      end else begin
        if (mif.mem_req && exp_q.size() > 0) begin
          n_chk++;
          if (mif.mem_addr !== exp_q[0].addr) begin
            n_fail++;
            $display("FAIL fetch_addr: got %h required %h", mif.mem_addr, exp_q[0].addr);
          end
        end
        if (mif.mem_req && mif.mem_ack) begin
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_ack: addr %h with no expectation queued", mif.mem_addr);
          end else begin
            cur = exp_q.pop_front();
            active = 1;
            ack_cyc = cyc;
          end
        end
        if (active && cyc == ack_cyc + 1) begin
          n_chk++;
          if ({opcode, opext, ra1, ra2, wa, use_imm, imm} !==
              {cur.opcode, cur.opext, cur.ra1, cur.ra2, cur.ra1, cur.use_imm, cur.imm}) begin
            n_fail++;
            $display("FAIL decode_fields: got op=%h ext=%h ra1=%h ra2=%h wa=%h ui=%b imm=%h required op=%h ext=%h ra1=%h ra2=%h wa=%h ui=%b imm=%h",
                     opcode, opext, ra1, ra2, wa, use_imm, imm,
                     cur.opcode, cur.opext, cur.ra1, cur.ra2, cur.ra1, cur.use_imm, cur.imm);
          end
        end
        if (active && !cur.halt && cyc == ack_cyc + 3) begin
          n_chk++;
          if (regwrite !== cur.rw || {opcode, wa, imm} !== {cur.opcode, cur.ra1, cur.imm}) begin
            n_fail++;
            $display("FAIL wb_cycle: got regwrite=%b op=%h wa=%h imm=%h required regwrite=%b op=%h wa=%h imm=%h",
                     regwrite, opcode, wa, imm, cur.rw, cur.opcode, cur.ra1, cur.imm);
          end
          retired++;
          active = 0;
        end else if (regwrite) begin
          n_chk++; n_fail++;
          $display("FAIL regwrite_stray: got regwrite=1 at cycle %0d required 0", cyc);
        end
        if (active && cur.halt && cyc == ack_cyc + 2) begin
          n_chk++;
          if (halted !== 1'b1 || mif.mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_entry: got halted=%b mem_req=%b required halted=1 mem_req=0", halted, mif.mem_req);
          end
          retired++;
          active = 0;
        end
        if (halted) begin
          n_chk++;
          if (mif.mem_req !== 1'b0 || regwrite !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_quiet: got mem_req=%b regwrite=%b required 0 0", mif.mem_req, regwrite);
          end
        end
      end
    end
  end

  task automatic check_all_zero(input string name);
    n_chk++;
    if ({mif.mem_req, mif.mem_addr, opcode, opext, ra1, ra2, wa, regwrite, use_imm, imm, halted} !== '0) begin
      n_fail++;
      $display("FAIL %s: got req=%b addr=%h op=%h ext=%h ra1=%h ra2=%h wa=%h rw=%b ui=%b imm=%h halted=%b required all 0",
               name, mif.mem_req, mif.mem_addr, opcode, opext, ra1, ra2, wa, regwrite, use_imm, imm, halted);
    end
  endtask

  task automatic drain(input int n, input string name);
    int target, budget;
    target = retired + n;
    budget = 0;
    while (retired < target && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    n_chk++;
    if (retired < target) begin
      n_fail++;
      $display("FAIL %s_timeout: retired %0d required %0d", name, retired, target);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset_state");

    // R-type ADD-class, immediate op, long memory wait, CMP forms, undefined op, MOVI, HALT
    issue(16'h0152, 8'd0, 16'h0000, 4'h0, 4'h5, 4'h1, 4'h2, 1'b0, 16'h0052, 1'b1, 1'b0);
    issue(16'h53F0, 8'd0, 16'h0001, 4'h5, 4'hF, 4'h3, 4'h0, 1'b1, 16'hFFF0, 1'b1, 1'b0);
    issue(16'h1A7F, 8'd7, 16'h0002, 4'h1, 4'h7, 4'hA, 4'hF, 1'b1, 16'h007F, 1'b1, 1'b0);
    issue(16'h01B2, 8'd0, 16'h0003, 4'h0, 4'hB, 4'h1, 4'h2, 1'b0, 16'hFFB2, 1'b0, 1'b0);
    issue(16'h2C34, 8'd1, 16'h0004, 4'h2, 4'h3, 4'hC, 4'h4, 1'b1, 16'h0034, 1'b0, 1'b0);
    issue(16'hB456, 8'd0, 16'h0005, 4'hB, 4'h5, 4'h4, 4'h6, 1'b1, 16'h0056, 1'b0, 1'b0);
    issue(16'hD0FE, 8'd2, 16'h0006, 4'hD, 4'hF, 4'h0, 4'hE, 1'b1, 16'hFFFE, 1'b1, 1'b0);
    issue(16'hFFFF, 8'd0, 16'h0007, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 16'hFFFF, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    drain(8, "program");

    // HALT is absorbing for well over 20 cycles
    repeat (25) @(negedge clk);
    n_chk++;
    if (halted !== 1'b1 || mif.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_hold: got halted=%b mem_req=%b required 1 0", halted, mif.mem_req);
    end
    rst = 1'b1;
    #1 check_all_zero("reset_from_halt");

    // PC wrap: deposit PC=FFFF right after reset release, then reset during WAIT
    issue(16'h2000, 8'd0,  16'hFFFF, 4'h2, 4'h0, 4'h0, 4'h0, 1'b1, 16'h0000, 1'b0, 1'b0);
    issue(16'h0000, 8'd30, 16'h0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0000, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    dut.pc_q = 16'hFFFF;
    drain(1, "wrap");
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_all_zero("reset_mid_wait");
    mem_q.delete();
    exp_q.delete();
    issue(16'h0321, 8'd0, 16'h0000, 4'h0, 4'h2, 4'h3, 4'h1, 1'b0, 16'h0021, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drain(1, "after_reset");
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
